uart_tx_8n1: RTL and testbench
==============================

Name: uart_tx_8n1

Overview:
- Serial UART transmitter for 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Takes a parallel byte through a valid/ready handshake and drives an idle-high serial line.
- Pairs with the existing 8N1 receiver at the same bit period (100 MHz / 115200 baud ≈ 868 clk per bit).
- Sits between the byte-producing logic and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit; legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; fixed at 8, exposed for the package constant only.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  tx_byte holds a byte to send
- tx_byte  in  8  byte to transmit
- tx_ready  out  1  block accepts a byte this cycle
- tx_busy  out  1  frame in progress (START, DATA, STOP or DONE)
- tx_done  out  1  one-cycle pulse when a frame's stop bit completes
- tx  out  1  serial line; idle high; registered output

Behaviour:
- Reset (async assert, sync-to-clk release): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0.
- Accept: on the rising edge where tx_valid && tx_ready, tx_byte is latched into the shift register.
  - Later changes on tx_byte do not affect the frame.
  - tx_valid while !tx_ready is ignored, not queued.
- States:
  - IDLE: tx=1, tx_ready=1. On accept → START.
  - START: tx=0 for exactly CLKS_PER_BIT cycles → DATA.
  - DATA: each bit drives tx for exactly CLKS_PER_BIT cycles, bit 0 first. The bit index counts 0..7; after bit 7 → STOP.
  - STOP: tx=1 for exactly CLKS_PER_BIT cycles → DONE.
  - DONE: one cycle; tx=1, tx_done=1 → IDLE (see optional feature).
- Latency: first start-bit cycle appears on tx the cycle after accept. tx_done is asserted 10*CLKS_PER_BIT+1 cycles after accept.
- Minimum frame-to-frame spacing: 10*CLKS_PER_BIT+2 cycles. This includes the DONE cycle and the IDLE accept cycle.
- Bit-period counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 on the same edge the bit advances.
  - Never exceeds CLKS_PER_BIT-1.
- tx_busy=1 in every state except IDLE.
- Reset mid-frame: tx returns to 1 immediately (async), the frame is abandoned, and no tx_done is produced. The downstream receiver sees a truncated frame; this is accepted.
- Illegal or unused state encodings recover to IDLE with tx=1 on the next edge.

Optional Feature:
- Macro: UART_TX_HOLD_EN.
- Defined:
  - Adds a one-entry holding register (hold_byte, hold_full).
  - tx_ready = !hold_full in all states, so a byte can be accepted during a frame.
  - From DONE, if hold_full: move hold_byte into the shift register, clear hold_full, go directly to START. Frames are then spaced 10*CLKS_PER_BIT+1 cycles apart.
  - In IDLE an accept goes straight to the shift register and bypasses the hold register.
  - If an accept coincides with DONE emptying the hold register, the new byte goes into hold. hold_full stays 1 and no byte is lost.
- Undefined:
  - tx_ready=1 only in IDLE; there is no hold register.
  - Behaviour is exactly as described in Behaviour.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, DONE}
  - default CLKS_PER_BIT=868
  - DATA_BITS=8
  - IDLE_LEVEL=1'b1
- One natural sub-module, uart_baud_cnt:
  - Parameterised bit-period counter with clear and enable.
  - Emits a one-cycle bit_end pulse at count CLKS_PER_BIT-1.
  - Reusable by the receiver later.

Test Plan:
- Single byte: CLKS_PER_BIT=8, send 0xA5 from IDLE → tx pattern 0,1,0,1,0,0,1,0,1,1, each level held 8 cycles. tx_done pulses once, 81 cycles after accept; tx_busy low again the following cycle.
- Ignored request: pulse tx_valid with 0x3C during the DATA state of a 0xFF frame (macro off) → the wire carries only the 0xFF frame; no second frame and no tx_done for 0x3C.
- Back-to-back (macro on): accept 0x01, then 0x80 during the first frame's DATA state → second start bit begins the cycle after the first DONE. Bits match 0x01 then 0x80; tx_done is seen twice; tx_ready drops while hold is full.
- Reset mid-frame: assert rst_n=0 in bit 4 of 0x55 → tx=1 within the same cycle and all outputs at reset values. After release, 0x0F sends correctly.
- Loopback: CLKS_PER_BIT=868, tx wired to the existing 8N1 receiver. Send 0x00, 0xFF, 0x5A, 0xC3 → the receiver outputs the identical bytes with one strobe per frame.
- Minimum period: CLKS_PER_BIT=2, send 0x96 → every bit lasts exactly 2 cycles, with no counter overflow or stuck state.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and default bit timing for the 8N1 TX/RX pair.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  localparam int   DEF_CLKS_PER_BIT = 868;
  localparam int   DATA_BITS        = 8;
  localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Wrap and bit advance happen on the same edge, so cnt never passes LAST.
  assign bit_end = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with valid/ready byte intake and registered, idle-high serial output.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_e          state;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 bit_end;
  logic                 cnt_en;
  logic                 accept;
  logic                 load_en;
  logic [DATA_BITS-1:0] load_byte;

  assign cnt_en = (state == START) || (state == DATA) || (state == STOP);
  assign accept = tx_valid && tx_ready;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!cnt_en),
    .en      (cnt_en),
    .bit_end (bit_end)
  );

`ifdef UART_TX_HOLD_EN
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_byte;
  logic                 launch_slot;
  logic                 direct_take;

  // IDLE and DONE are the only states that can start a new frame.
  assign launch_slot = (state == IDLE) || (state == DONE);
  assign direct_take = accept && launch_slot && !hold_full;
  assign tx_ready    = !hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
    end else if (accept && !direct_take) begin
      hold_full <= 1'b1;
    end else if (launch_slot && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !direct_take) begin
      hold_byte <= tx_byte;
    end
  end

  always_comb begin
    load_en   = 1'b0;
    load_byte = tx_byte;
    if (launch_slot && hold_full) begin
      load_en   = 1'b1;
      load_byte = hold_byte;
    end else if (direct_take) begin
      load_en   = 1'b1;
    end
  end
`else
  assign tx_ready = (state == IDLE);

  always_comb begin
    load_en   = (state == IDLE) && accept;
    load_byte = tx_byte;
  end
`endif

  assign tx_busy = (state != IDLE);

  // Data bits leave LSB-first; the register shifts as each data bit ends.
  always_ff @(posedge clk) begin
    if (load_en) begin
      shift_reg <= load_byte;
    end else if ((state == DATA) && bit_end) begin
      shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      tx_done <= 1'b0;
      bit_idx <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load_en) begin
            state <= START;
            tx    <= 1'b0;
          end else begin
            state <= IDLE;
            tx    <= IDLE_LEVEL;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift_reg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= IDLE_LEVEL;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift_reg[1];
            end
          end
        end
        STOP: begin
          tx <= IDLE_LEVEL;
          if (bit_end) begin
            state   <= DONE;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: one instance at 8 clk/bit, one at the 2 clk/bit minimum.
module tb_uart_tx_8n1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid [2];
  logic [7:0] tx_byte  [2];
  logic       tx_ready [2];
  logic       tx_busy  [2];
  logic       tx_done  [2];
  logic       tx       [2];

  always #5 clk = ~clk;

  uart_tx_8n1 #(.CLKS_PER_BIT(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[0]), .tx_byte(tx_byte[0]),
    .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx(tx[0])
  );

  uart_tx_8n1 #(.CLKS_PER_BIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid[1]), .tx_byte(tx_byte[1]),
    .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx(tx[1])
  );

  typedef struct {
    int         d;
    logic [7:0] b;
    logic [9:0] f;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_bad = 0;
  logic smp_tx    [0:255];
  logic smp_busy  [0:255];
  logic smp_done  [0:255];
  logic smp_ready [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nof(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // Accept b on DUT d, then record ncyc cycles; index 0 is the accept cycle.
  task automatic send(input int d, input logic [7:0] b, input int poke_at,
                      input logic [7:0] poke_b, input int ncyc);
    @(negedge clk);
    smp_ready[0] = tx_ready[d];
    tx_valid[d] = 1'b1;
    tx_byte[d]  = b;
    @(posedge clk);
    #1;
    tx_valid[d] = 1'b0;
    tx_byte[d]  = ~b;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      smp_tx[c]    = tx[d];
      smp_busy[c]  = tx_busy[d];
      smp_done[c]  = tx_done[d];
      smp_ready[c] = tx_ready[d];
      tx_valid[d]  = (c == poke_at);
      tx_byte[d]   = (c == poke_at) ? poke_b : ~b;
    end
    tx_valid[d] = 1'b0;
  endtask

  function automatic logic [9:0] cap_frame(input int n, input int base);
    logic [9:0] f;
    for (int i = 0; i < 10; i++) f[i] = smp_tx[base + i*n + n/2];
    return f;
  endfunction

  function automatic int stable_bits(input int n, input int base);
    int good = 0;
    for (int i = 0; i < 10; i++) begin
      bit ok = 1'b1;
      for (int k = 0; k < n; k++)
        if (smp_tx[base + i*n + k] !== smp_tx[base + i*n]) ok = 1'b0;
      if (ok) good++;
    end
    return good;
  endfunction

  function automatic int count_done(input int ncyc);
    int cnt = 0;
    for (int c = 1; c <= ncyc; c++) if (smp_done[c] === 1'b1) cnt++;
    return cnt;
  endfunction

  function automatic int done_at(input int k, input int ncyc);
    int seen = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (smp_done[c] === 1'b1) begin
        seen++;
        if (seen == k) return c;
      end
    end
    return -1;
  endfunction

  task automatic run_vec(input int d, input logic [7:0] b, input logic [9:0] f);
    int    n    = nof(d);
    int    last = 10*n + 2;
    string tag  = $sformatf("d%0d_%h", d, b);
    send(d, b, 0, 8'h00, last);
    chk({tag, "_ready_idle"}, smp_ready[0], 1);
    chk({tag, "_frame"}, cap_frame(n, 1), f);
    chk({tag, "_bit_width"}, stable_bits(n, 1), 10);
    chk({tag, "_busy_start"}, smp_busy[1], 1);
    chk({tag, "_done_cnt"}, count_done(last), 1);
    chk({tag, "_done_lat"}, done_at(1, last), 10*n + 1);
    chk({tag, "_busy_after"}, smp_busy[last], 0);
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 10'b1101001010};
    vecs[1] = '{0, 8'h00, 10'b1000000000};
    vecs[2] = '{0, 8'h5A, 10'b1010110100};
    vecs[3] = '{0, 8'hC3, 10'b1110000110};
    vecs[4] = '{1, 8'h96, 10'b1100101100};
    vecs[5] = '{1, 8'hFF, 10'b1111111110};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tx_valid[d] = 1'b0;
      tx_byte[d]  = 8'h00;
    end
    @(negedge clk);
    chk("rst_tx", tx[0], 1);
    chk("rst_ready", tx_ready[0], 1);
    chk("rst_busy", tx_busy[0], 0);
    chk("rst_done", tx_done[0], 0);
    chk("rst_tx_min", tx[1], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i].d, vecs[i].b, vecs[i].f);

`ifdef UART_TX_HOLD_EN
    // Second byte arrives during DATA of the first and is launched straight out of DONE.
    send(0, 8'h01, 24, 8'h80, 164);
    chk("hold_ready_before", smp_ready[24], 1);
    chk("hold_ready_full", smp_ready[25], 0);
    chk("hold_frame1", cap_frame(8, 1), 10'b1000000010);
    chk("hold_frame2", cap_frame(8, 82), 10'b1100000000);
    chk("hold_width2", stable_bits(8, 82), 10);
    chk("hold_done_cnt", count_done(164), 2);
    chk("hold_done1", done_at(1, 164), 81);
    chk("hold_done2", done_at(2, 164), 162);
    chk("hold_ready_drained", smp_ready[82], 1);
    chk("hold_busy_after", smp_busy[163], 0);
`else
    // A request during DATA must be dropped, not queued.
    send(0, 8'hFF, 24, 8'h3C, 164);
    begin
      int lows = 0;
      for (int c = 82; c <= 164; c++) if (smp_tx[c] !== 1'b1) lows++;
      chk("ign_ready_data", smp_ready[24], 0);
      chk("ign_frame", cap_frame(8, 1), 10'b1111111110);
      chk("ign_done_cnt", count_done(164), 1);
      chk("ign_done_lat", done_at(1, 164), 81);
      chk("ign_line_quiet", lows, 0);
      chk("ign_busy_after", smp_busy[164], 0);
    end
`endif

    // Reset asserted during data bit 4 of 0x55.
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_byte[0]  = 8'h55;
    @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    repeat (43) @(negedge clk);
    chk("mid_busy_pre", tx_busy[0], 1);
    chk("mid_ready_pre", tx_ready[0], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx[0], 1);
    chk("mid_rst_busy", tx_busy[0], 0);
    chk("mid_rst_ready", tx_ready[0], 1);
    chk("mid_rst_done", tx_done[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idle_tx", tx[0], 1);
    run_vec(0, 8'h0F, 10'b1000011110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
